multicycle_controller: RTL and testbench

Control unit for the multicycle RV32I core: an 11-state main FSM plus an ALU decoder and an immediate-select decoder that sequence a shared-memory datapath (one instruction/data memory, with IR, OldPC, A, WriteData, ALUOut and Data registers). It replaces the single-cycle combinational decoder. One instruction is fetched, decoded and executed over 3–5 cycles. The datapath register enables and mux selects are driven from the current state and the instruction fields.

---
 rtl/riscv_multi_pkg.sv | 58 +++++
 rtl/multicycle_controller_if.sv | 29 ++
 rtl/alu_decoder.sv | 19 +
 rtl/multicycle_controller.sv | 106 ++++++++++
 tb/tb_multicycle_controller.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/riscv_multi_pkg.sv
// riscv_multi_pkg: shared state, opcode and control encodings for the multicycle RV32I control unit.
package riscv_multi_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, ALUWB, EXECUTEI, JAL, BEQ
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
    } ctrl_t;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        return op == OP_SW ? IMM_S : op == OP_BEQ ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
    endfunction
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields and Zero in, datapath enables and selects out.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic [1:0] ImmSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       AdrSrc;
    logic [2:0] ALUControl;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] State;

    modport master (
        input  op, funct3, funct7b5, Zero,
        output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
               IRWrite, PCWrite, RegWrite, MemWrite, State
    );
    modport slave (
        output op, funct3, funct7b5, Zero,
        input  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
               IRWrite, PCWrite, RegWrite, MemWrite, State
    );
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp and instruction function bits to an ALUControl code.
module alu_decoder
    import riscv_multi_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] ALUControl
);
    always_comb begin
        ALUControl = ALUOp == ALUOP_SUB ? ALU_SUB :
                     ALUOp != ALUOP_FUNCT ? ALU_ADD :
                     funct3 == 3'b000 ? ((op5 & funct7b5) ? ALU_SUB : ALU_ADD) :
                     funct3 == 3'b010 ? ALU_SLT :
                     funct3 == 3'b110 ? ALU_OR :
                     funct3 == 3'b111 ? ALU_AND : ALU_ADD;
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: 11-state Moore FSM sequencing the shared-memory multicycle RV32I datapath.
module multicycle_controller
    import riscv_multi_pkg::*;
(
    input  logic clk,
    input  logic reset,
    multicycle_controller_if.master bus
);
    state_t     state, next;
    ctrl_t      c;
    logic [2:0] alu_control;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else state <= next;
    end

    always_comb begin
        next = FETCH;
        case (state)
            FETCH:    next = DECODE;
            DECODE:   next = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                             bus.op == OP_R ? EXECUTER :
                             bus.op == OP_I ? EXECUTEI :
                             bus.op == OP_JAL ? JAL :
                             bus.op == OP_BEQ ? BEQ : FETCH;
            MEMADR:   next = bus.op == OP_LW ? MEMREAD : MEMWRITE;
            MEMREAD:  next = MEMWB;
            EXECUTER: next = ALUWB;
            EXECUTEI: next = ALUWB;
            JAL:      next = ALUWB;
            default:  next = FETCH;
        endcase
    end

    // Every field defaults to zero, so each state lists only what it asserts.
    always_comb begin
        c = '0;
        case (state)
            FETCH: begin
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
                c.ir_write   = 1'b1;
                c.pc_update  = 1'b1;
            end
            DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_IMM;
            end
            MEMREAD:  c.adr_src = 1'b1;
            MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            EXECUTER: begin
                c.alu_src_a = SRCA_A;
                c.alu_op    = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            ALUWB:    c.reg_write = 1'b1;
            JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_update = 1'b1;
            end
            BEQ: begin
                c.alu_src_a = SRCA_A;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            default: c = '0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (c.alu_op),
        .funct3     (bus.funct3),
        .op5        (bus.op[5]),
        .funct7b5   (bus.funct7b5),
        .ALUControl (alu_control)
    );

    assign bus.ImmSrc     = imm_src(bus.op);
    assign bus.ALUSrcA    = c.alu_src_a;
    assign bus.ALUSrcB    = c.alu_src_b;
    assign bus.ResultSrc  = c.result_src;
    assign bus.AdrSrc     = c.adr_src;
    assign bus.ALUControl = alu_control;
    assign bus.IRWrite    = c.ir_write;
    assign bus.PCWrite    = c.pc_update | (c.branch & bus.Zero);
    assign bus.RegWrite   = c.reg_write;
    assign bus.MemWrite   = c.mem_write;
    assign bus.State      = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench comparing every cycle's outputs against a per-instruction reference model.
module tb_multicycle_controller;
    typedef int iq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mon_en = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [19:0] sb[$];

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] actual();
        return {bus.State, bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc,
                bus.ALUControl, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite};
    endfunction

    function automatic logic [2:0] alu_for(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        if (f3 == 3'd0) return (o[5] && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'd2) return 3'b101;
        if (f3 == 3'd6) return 3'b011;
        if (f3 == 3'd7) return 3'b010;
        return 3'b000;
    endfunction

    // Expected outputs for one cycle spent in state st while executing instruction o.
    function automatic logic [19:0] model(input int st, input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z);
        logic [1:0] imm, a, b, res;
        logic [2:0] alu;
        logic adr, irw, pcw, rw, mw;
        imm = o == 7'b0100011 ? 2'd1 : o == 7'b1100011 ? 2'd2 : o == 7'b1101111 ? 2'd3 : 2'd0;
        a = 2'd0; b = 2'd0; res = 2'd0; alu = 3'b000;
        adr = 1'b0; irw = 1'b0; pcw = 1'b0; rw = 1'b0; mw = 1'b0;
        case (st)
            0: begin b = 2'd2; res = 2'd2; irw = 1'b1; pcw = 1'b1; end
            1: begin a = 2'd1; b = 2'd1; end
            2: begin a = 2'd2; b = 2'd1; end
            3: adr = 1'b1;
            4: begin res = 2'd1; rw = 1'b1; end
            5: begin adr = 1'b1; mw = 1'b1; end
            6: begin a = 2'd2; alu = alu_for(o, f3, f7); end
            7: rw = 1'b1;
            8: begin a = 2'd2; b = 2'd1; alu = alu_for(o, f3, f7); end
            9: begin a = 2'd1; b = 2'd2; pcw = 1'b1; end
            10: begin a = 2'd2; alu = 3'b001; pcw = z; end
            default: ;
        endcase
        return {4'(st), imm, a, b, res, adr, alu, irw, pcw, rw, mw};
    endfunction

    function automatic iq_t seq_of(input logic [6:0] o);
        case (o)
            7'b0000011: return '{0, 1, 2, 3, 4};
            7'b0100011: return '{0, 1, 2, 5};
            7'b0110011: return '{0, 1, 6, 7};
            7'b0010011: return '{0, 1, 8, 7};
            7'b1101111: return '{0, 1, 9, 7};
            7'b1100011: return '{0, 1, 10};
            default:    return '{0, 1};
        endcase
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int zsel);
        iq_t s;
        s = seq_of(o);
        bus.op = o;
        bus.funct3 = f3;
        bus.funct7b5 = f7;
        foreach (s[i]) begin
            bus.Zero = zsel == 2 ? 1'($urandom_range(0, 1)) : 1'(zsel);
            sb.push_back(model(s[i], o, f3, f7, bus.Zero));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (sb.size() == 0) check("sb_underflow", actual(), 20'hfffff ^ actual());
                else check("cycle", actual(), sb.pop_front());
            end
        end
    end

    initial begin
        logic [6:0] o;
        logic [6:0] ops[6];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
        bus.op = 7'b0110011;
        bus.funct3 = 3'd0;
        bus.funct7b5 = 1'b0;
        bus.Zero = 1'b0;
        #3;
        check("reset_hold", actual(), model(0, bus.op, 3'd0, 1'b0, 1'b0));
        @(posedge clk);
        #2;
        check("reset_across_edge", actual(), model(0, bus.op, 3'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        run_instr(7'b0000011, 3'd2, 1'b0, 2);
        run_instr(7'b0100011, 3'd2, 1'b1, 2);
        run_instr(7'b0110011, 3'd0, 1'b1, 2);
        run_instr(7'b0110011, 3'd0, 1'b0, 2);
        run_instr(7'b0110011, 3'd7, 1'b0, 2);
        run_instr(7'b0010011, 3'd0, 1'b1, 2);
        run_instr(7'b1100011, 3'd0, 1'b0, 1);
        run_instr(7'b1100011, 3'd0, 1'b0, 0);
        run_instr(7'b1101111, 3'd5, 1'b1, 2);
        run_instr(7'b1111111, 3'd0, 1'b0, 2);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) < 6) o = ops[$urandom_range(0, 5)];
            else begin
                o = 7'($urandom);
                while (o inside {ops}) o = 7'($urandom);
            end
            run_instr(o, 3'($urandom), 1'($urandom), 2);
        end
        mon_en = 1'b0;
        check("sb_drained", 20'(sb.size()), 20'd0);
        // Abort a load in MEMREAD with an asynchronous reset between clock edges.
        bus.op = 7'b0000011;
        bus.funct3 = 3'd2;
        bus.Zero = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("pre_abort_memread", actual(), model(3, 7'b0000011, 3'd2, bus.funct7b5, 1'b1));
        #1;
        reset = 1'b1;
        #1;
        check("abort_to_fetch", actual(), model(0, 7'b0000011, 3'd2, bus.funct7b5, 1'b1));
        check("abort_no_writes", 20'({bus.MemWrite, bus.RegWrite}), 20'd0);
        @(posedge clk);
        #1;
        check("abort_hold", actual(), model(0, 7'b0000011, 3'd2, bus.funct7b5, 1'b1));
        reset = 1'b0;
        #3;
        check("release_fetch", actual(), model(0, 7'b0000011, 3'd2, bus.funct7b5, 1'b1));
        @(posedge clk);
        #1;
        check("release_decode", actual(), model(1, 7'b0000011, 3'd2, bus.funct7b5, 1'b1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
